// File: rtl/motor_pkg.sv
// motor_pkg: shared widths and FSM state encoding for the motor scheduler.
//   NUM_MOTORS - number of motors sharing the speed controller
//   VEL_W      - speed width (0..15)
//   SEL_W      - motor index width
package motor_pkg;
    localparam int NUM_MOTORS = 4;
    localparam int VEL_W      = 4;
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
endpackage

// File: rtl/motor_scheduler_if.sv
// motor_scheduler_if: target-speed command channel (valid/ready).
//   cmd_valid - command present
//   cmd_ready - command accepted this cycle when cmd_valid=1
//   cmd_motor - target motor index
//   cmd_vel   - target speed
interface motor_scheduler_if;
    import motor_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_motor;
    logic [VEL_W-1:0] cmd_vel;

    modport master (output cmd_valid, output cmd_motor, output cmd_vel, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_motor, input  cmd_vel, output cmd_ready);
endinterface

// File: rtl/motor_scheduler_speed_ramp.sv
// speed_ramp: per-motor target/current speed holder with one-step ramping.
//   clk, rst_n    - clock, synchronous active-low reset
//   wr_i, wdata_i - target write strobe and value
//   tick_i        - ramp step strobe; cur moves one step toward target
//   force_zero_i  - drive target to zero (overrides writes)
//   cur_o         - current speed
//   mismatch_o    - cur differs from target
module speed_ramp
    import motor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [VEL_W-1:0] wdata_i,
    input  logic             tick_i,
    input  logic             force_zero_i,
    output logic [VEL_W-1:0] cur_o,
    output logic             mismatch_o
);
    logic [VEL_W-1:0] tgt_q, tgt_d;
    logic [VEL_W-1:0] cur_q, cur_d;

    // The step compares against tgt_q, so a write on a tick edge only
    // affects the following tick.
    always_comb begin
        tgt_d = tgt_q;
        if (force_zero_i)
            tgt_d = '0;
        else if (wr_i)
            tgt_d = wdata_i;

        cur_d = cur_q;
        if (tick_i) begin
            if (cur_q < tgt_q)
                cur_d = cur_q + 1'b1;
            else if (cur_q > tgt_q)
                cur_d = cur_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_q <= '0;
            cur_q <= '0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    assign cur_o      = cur_q;
    assign mismatch_o = (cur_q != tgt_q);
endmodule

// File: rtl/motor_scheduler.sv
// motor_scheduler: ramps four motor speeds toward their targets and
// time-multiplexes one shared speed controller round-robin across the
// motors that are currently moving.
//   clk, rst_n  - clock, synchronous active-low reset
//   cmd         - target-speed command channel (slave side)
//   stop_all    - level emergency stop; ramps all motors to zero
//   enable      - controller enable
//   seletor     - controller motor select
//   velocidade  - controller speed
//   busy        - some motor has not yet reached its target
module motor_scheduler
    import motor_pkg::*;
#(
    parameter int SLOT_LEN = 8,
    parameter int RAMP_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    motor_scheduler_if.slave      cmd,
    input  logic                  stop_all,
    output logic                  enable,
    output logic [SEL_W-1:0]      seletor,
    output logic [VEL_W-1:0]      velocidade,
    output logic                  busy
);
    localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    state_e                           state_q, state_d;
    logic [SEL_W-1:0]                 sel_q, sel_d;
    logic [SLOT_W-1:0]                slot_q, slot_d;
    logic [RAMP_W-1:0]                ramp_q, ramp_d;
    logic                             rdy_q;

    logic [NUM_MOTORS-1:0][VEL_W-1:0] cur;
    logic [NUM_MOTORS-1:0]            mism;
    logic [NUM_MOTORS-1:0]            nz;
    logic                             tick, hs, any_nz, slot_end;
    logic [SEL_W-1:0]                 first_nz, next_nz;

    assign tick   = (ramp_q == RAMP_W'(RAMP_DIV - 1));
    assign ramp_d = tick ? '0 : ramp_q + 1'b1;
    assign hs     = cmd.cmd_valid & rdy_q;

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_mot
        speed_ramp u_ramp (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_i         (hs && (cmd.cmd_motor == SEL_W'(i))),
            .wdata_i      (cmd.cmd_vel),
            .tick_i       (tick),
            .force_zero_i (state_q == HALT),
            .cur_o        (cur[i]),
            .mismatch_o   (mism[i])
        );
        assign nz[i] = |cur[i];
    end

    assign any_nz   = |nz;
    assign slot_end = (slot_q == SLOT_W'(SLOT_LEN - 1));

    // first_nz: lowest active index. next_nz: search sel+1, +2, +3 (mod 4)
    // and fall back to sel itself; the index wraps naturally at SEL_W bits.
    always_comb begin
        first_nz = '0;
        for (int i = NUM_MOTORS - 1; i >= 0; i--)
            if (nz[i]) first_nz = SEL_W'(i);
        next_nz = sel_q;
        for (int k = NUM_MOTORS - 1; k >= 1; k--)
            if (nz[sel_q + SEL_W'(k)]) next_nz = sel_q + SEL_W'(k);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (stop_all) begin
                    state_d = HALT;
                end else if (any_nz) begin
                    state_d = RUN;
                    sel_d   = first_nz;
                    slot_d  = '0;
                end
            end
            RUN, HALT: begin
                if (slot_end) begin
                    slot_d = '0;
                    if (any_nz) sel_d = next_nz;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
                if (state_q == RUN) begin
                    if (stop_all) begin
                        state_d = HALT;
                        sel_d   = sel_q;   // stop wins over the slot advance
                    end else if (slot_end && !any_nz) begin
                        state_d = IDLE;
                    end
                end else if (!any_nz && !stop_all) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            slot_q  <= '0;
            ramp_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            ramp_q  <= ramp_d;
            rdy_q   <= (state_d != HALT);   // registered so ready tracks state
        end
    end

    assign cmd.cmd_ready = rdy_q;
    assign seletor       = sel_q;
    assign enable        = (state_q != IDLE) && nz[sel_q];
    assign velocidade    = (state_q == IDLE) ? '0 : cur[sel_q];
    assign busy          = |mism;
endmodule

// File: doc/motor_scheduler.md
Name: motor_scheduler

Overview:
- Sequencer placed in front of the 4-motor speed controller. It drives that controller's enable, seletor and velocidade inputs.
- Holds one target speed per motor, written over a valid/ready command port.
- Ramps each motor's current speed one step at a time toward its target (soft start and soft stop).
- Time-multiplexes the shared controller round-robin across motors whose current speed is nonzero. Provides an emergency stop_all that ramps every motor to zero.

Parameters:
- SLOT_LEN, 8: clock cycles the controller stays on one motor before moving to the next; must be >= 1.
- RAMP_DIV, 16: clock cycles between ramp steps; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle if cmd_valid=1.
- cmd_motor  in  2  target motor index 0..3.
- cmd_vel  in  4  target speed 0..15.
- stop_all  in  1  level-sensitive emergency stop.
- enable  out  1  to controller enable.
- seletor  out  2  to controller seletor.
- velocidade  out  4  to controller velocidade.
- busy  out  1  high while any current speed differs from its target.

Behaviour:
- Reset (clock edge with rst_n=0):
  - All target[i]=0 and cur[i]=0; ramp counter=0; slot counter=0; state=IDLE.
  - Outputs: enable=0, seletor=0, velocidade=0, cmd_ready=0, busy=0.
  - Reset mid-operation discards all state. No ramp-down occurs.
- All outputs are derived only from registers; there is no combinational path from any input to any output.
- Commands:
  - cmd_ready=1 in IDLE and RUN, 0 in HALT and during reset.
  - A handshake (cmd_valid & cmd_ready) writes target[cmd_motor]=cmd_vel at that edge.
  - A handshake is a single-cycle transfer with no buffering. Repeated writes to the same motor: last write wins.
- Ramp:
  - The ramp counter counts 0..RAMP_DIV-1 and wraps; it runs in every state.
  - On the wrap edge, each motor with cur<target increments by 1, and each motor with cur>target decrements by 1. Arithmetic is unsigned 4-bit with no overflow possible.
  - A command landing on the same edge as a ramp tick: the tick uses the old target, and the new target applies from the next tick.
- busy = OR over i of (cur[i]!=target[i]).
- States:
  - IDLE: enable=0, seletor held, velocidade=0. Go to HALT if stop_all=1, else go to RUN when any cur!=0. Entry into RUN loads seletor with the lowest-index motor whose cur!=0 and clears the slot counter.
  - RUN: enable=(cur[seletor]!=0), velocidade=cur[seletor].
    - Slot counter increments each cycle.
    - When it reaches SLOT_LEN-1, seletor moves to the next motor with cur!=0, searching seletor+1, +2, +3 modulo 4, then seletor itself; the slot counter then clears.
    - If all cur==0 at the slot end, go to IDLE.
    - stop_all=1 goes to HALT on the next edge and takes priority over the slot advance.
  - HALT: all targets forced to 0 every cycle; commands blocked; scheduling is identical to RUN.
    - When all cur==0: enable=0.
    - Go to IDLE once all cur==0 and stop_all=0.
- Boundary cases:
  - A motor whose cur reaches 0 mid-slot keeps its slot until the slot ends, with enable=0 for the remainder.
  - A single active motor occupies every slot back-to-back.
  - cmd_vel=0 on an active motor ramps it down, after which it is skipped.

Decomposition:
- Package motor_pkg holds:
  - NUM_MOTORS=4, VEL_W=4, SEL_W=2.
  - The state enum {IDLE, RUN, HALT}.
- Sub-module speed_ramp: one per motor. Holds target/cur, takes a write strobe, a tick and a force_zero input, and outputs cur and a mismatch flag. Instantiated 4 times.
- Top level holds the FSM, slot counter, round-robin search and ramp divider.

Test Plan:
- Release reset with cmd_valid=0 -> all outputs 0 for 100 cycles; cmd_ready=1 from the first cycle after release.
- Write motor1=3 at cycle 2 -> cur1 reaches 1, 2, 3 on the first three ramp ticks. RUN is entered after the first tick with seletor=1, enable=1, velocidade tracking cur1. busy drops after the third tick.
- motor0=2 and motor2=5 active -> seletor alternates 0,2,0,2, each for exactly 8 cycles. Motors 1 and 3 are never selected.
- Assert stop_all with motor2 at 5 -> cmd_ready=0 and a write attempt is ignored. velocidade steps 5→0 over 5 ticks, then enable=0. Deassert stop_all -> IDLE, cmd_ready=1.
- Issue a command on the exact ramp-tick edge (motor3 from cur=2 to target=0) -> the tick uses the old target; the decrement starts at the following tick.
- Assert rst_n=0 for one cycle mid-RUN with three motors active -> the next cycle shows all outputs 0, IDLE, all targets 0.
